loop_prbs_checker: RTL and testbench

//  Receive-side checker of the data loop: takes looped-back bytes, self-synchronises to the PRBS-7 pattern and counts byte/bit errors.

---
 rtl/loop_prbs_checker_if.sv | 26 ++
 rtl/loop_prbs_checker.sv | 160 ++++++++++++++++
 tb/tb_loop_prbs_checker.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_prbs_checker_if.sv
// Byte link of the loop checker: the looped-back receive byte stream
// and its one-cycle-late forward copy to the bandwidth counter.
// valid/ready: there is no ready; a byte is transferred on every clk edge
// where its valid is 1, and the receiver must always accept it.
interface loop_prbs_checker_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       data_valid;
    logic [7:0] data;

    // Upstream side: supplies looped-back bytes, observes the forward copy.
    modport master (
        output rx_valid,
        output rx_data,
        input  data_valid,
        input  data
    );

    // Checker side.
    modport slave (
        input  rx_valid,
        input  rx_data,
        output data_valid,
        output data
    );
endinterface

// File: rtl/loop_prbs_checker.sv
// Receive-side PRBS-7 checker of the data loop. Self-synchronises to the
// x^7+x^6+1 pattern from the incoming bytes, counts byte and bit errors
// while locked, and forwards the raw byte stream one cycle late.
module loop_prbs_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    loop_prbs_checker_if.slave  lp,
    input  logic                err_clr,
    output logic                locked,
    output logic [31:0]         err_bytes,
    output logic [31:0]         err_bits
);

    localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    logic [6:0]    lfsr;
    logic [MW-1:0] match_cnt;
    logic [LW-1:0] miss_cnt;

    logic [7:0]    exp_byte;
    logic [7:0]    diff;
    logic          is_match;
    logic          seed_ok;
    logic [3:0]    bit_errs;
    logic [32:0]   bits_sum;
    logic          err_event;

    // Eight serial PRBS-7 steps, MSB first; the final state equals result[6:0].
    function automatic logic [7:0] prbs_byte(input logic [6:0] seed);
        logic [6:0] s;
        logic       n;
        logic [7:0] r;
        s = seed;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            n        = s[6] ^ s[5];
            r[7 - i] = n;
            s        = {s[5:0], n};
        end
        return r;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Prediction of the current byte and its error signature.
    always_comb begin
        exp_byte  = prbs_byte(lfsr);
        diff      = lp.rx_data ^ exp_byte;
        is_match  = (diff == 8'h00);
        seed_ok   = (lp.rx_data[6:0] != 7'h00);
        bit_errs  = popcount8(diff);
        bits_sum  = {1'b0, err_bits} + {29'd0, bit_errs};
        err_event = lp.rx_valid && (state == LOCKED) && !is_match;
    end

    // Forward copy of the raw stream, independent of lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp.data_valid <= 1'b0;
            lp.data       <= 8'h00;
        end else begin
            lp.data_valid <= lp.rx_valid;
            if (lp.rx_valid) begin
                lp.data <= lp.rx_data;
            end
        end
    end

    // Synchronisation FSM; the LFSR free-runs once locked so errored bytes never corrupt it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            lfsr      <= 7'h00;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
        end else if (lp.rx_valid) begin
            case (state)
                SEARCH: begin
                    if (seed_ok) begin
                        lfsr      <= lp.rx_data[6:0];
                        match_cnt <= '0;
                        state     <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_match) begin
                        lfsr <= exp_byte[6:0];
                        if (match_cnt == LOCK_LAST) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + MW'(1);
                        end
                    end else if (seed_ok) begin
                        lfsr      <= lp.rx_data[6:0];
                        match_cnt <= '0;
                    end else begin
                        state <= SEARCH;
                    end
                end
                LOCKED: begin
                    lfsr <= exp_byte[6:0];
                    if (is_match) begin
                        miss_cnt <= '0;
                    end else if (miss_cnt == LOSS_LAST) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        miss_cnt <= '0;
                    end else begin
                        miss_cnt <= miss_cnt + LW'(1);
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Saturating error counters; a clear drops any error in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bytes <= 32'h0;
            err_bits  <= 32'h0;
        end else if (err_clr) begin
            err_bytes <= 32'h0;
            err_bits  <= 32'h0;
        end else if (err_event) begin
            if (err_bytes != 32'hFFFF_FFFF) begin
                err_bytes <= err_bytes + 32'd1;
            end
            err_bits <= bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
        end
    end

endmodule

// File: tb/tb_loop_prbs_checker.sv
// Self-checking bench for loop_prbs_checker: directed scenarios plus a
// randomized stream, all compared against a bit-history reference model.
module tb_loop_prbs_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 8;
    localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

    typedef bit bitq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic [31:0] err_bytes;
    logic [31:0] err_bits;

    int errors = 0;
    int checks = 0;

    loop_prbs_checker_if lp ();

    loop_prbs_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lp        (lp),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_bytes (err_bytes),
        .err_bits  (err_bits)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Reference model: the stream is a sequence of bits where each new bit is
    // the XOR of the bits 7 and 6 positions back.  hist holds the last 7 bits.
    int         m_mode;      // 0 searching, 1 verifying, 2 locked
    bitq_t      m_hist;
    int         m_good;
    int         m_bad;
    longint     m_eby;
    longint     m_ebi;
    logic       m_dv;
    logic [7:0] m_data;
    bitq_t      gen_hist;    // generator of the clean stream

    function automatic bitq_t hist_of(input logic [7:0] b);
        bitq_t q;
        for (int i = 6; i >= 0; i--) q.push_back(b[i]);
        return q;
    endfunction

    function automatic logic [7:0] next_byte(input bitq_t h);
        bitq_t      q;
        logic [7:0] r;
        bit         nb;
        q = h;
        for (int i = 0; i < 8; i++) begin
            nb = q[0] ^ q[1];
            q.push_back(nb);
            void'(q.pop_front());
            r[7 - i] = nb;
        end
        return r;
    endfunction

    function automatic longint sat(input longint v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_bad = 0;
        m_eby = 0; m_ebi = 0; m_dv = 1'b0; m_data = 8'h00;
        m_hist = hist_of(8'h00);
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
        logic [7:0] e;
        m_dv = v;
        if (v) begin
            m_data = d;
            if (m_mode == 0) begin
                if (d[6:0] != 7'h00) begin m_hist = hist_of(d); m_good = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                e = next_byte(m_hist);
                if (d == e) begin
                    m_hist = hist_of(e);
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
                end else if (d[6:0] != 7'h00) begin
                    m_hist = hist_of(d); m_good = 0;
                end else begin
                    m_mode = 0;
                end
            end else begin
                e = next_byte(m_hist);
                m_hist = hist_of(e);
                if (d == e) begin
                    m_bad = 0;
                end else begin
                    if (!clr) begin
                        m_eby = sat(m_eby + 1);
                        m_ebi = sat(m_ebi + $countones(d ^ e));
                    end
                    m_bad++;
                    if (m_bad == LOSS_CNT) m_mode = 0;
                end
            end
        end
        if (clr) begin m_eby = 0; m_ebi = 0; end
    endtask

    task automatic gen_next(output logic [7:0] b);
        b = next_byte(gen_hist);
        gen_hist = hist_of(b);
    endtask

    // Driver: one clock of stimulus, model advanced at the sampling edge,
    // returns 1 time unit after the edge with inputs idled.
    task automatic send(input logic v, input logic [7:0] d, input logic clr);
        @(negedge clk);
        lp.rx_valid = v;
        lp.rx_data  = d;
        err_clr     = clr;
        @(posedge clk);
        model_step(v, d, clr);
        #1;
        lp.rx_valid = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lp.rx_valid = 1'($urandom_range(0, 1));
            lp.rx_data  = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({locked, lp.data_valid, lp.data, err_bytes, err_bits} !== 74'h0) begin
                errors++;
                $display("FAIL reset_outputs: got lk=%b dv=%b d=%h eby=%h ebi=%h expected all 0",
                         locked, lp.data_valid, lp.data, err_bytes, err_bits);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        lp.rx_valid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (dut.state !== 2'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got state=%0d locked=%b expected state=0 locked=0", dut.state, locked);
        end
    endtask

    task automatic test_clean_lock();
        logic [7:0] g;
        gen_hist = hist_of(8'hFF);
        send(1'b1, 8'hFF, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            gen_next(g);
            send(1'b1, g, 1'b0);
            if (k == 1) begin
                checks++;
                if (lp.data !== 8'h02) begin
                    errors++;
                    $display("FAIL clean_second_byte: got %h expected 02", lp.data);
                end
            end
            checks++;
            if (locked !== (k >= LOCK_CNT) || locked !== (m_mode == 2)) begin
                errors++;
                $display("FAIL clean_lock_timing byte %0d: got locked=%b expected %b", k + 1, locked, (k >= LOCK_CNT));
            end
            checks++;
            if (lp.data_valid !== 1'b1 || lp.data !== g) begin
                errors++;
                $display("FAIL clean_passthrough: got dv=%b d=%h expected dv=1 d=%h", lp.data_valid, lp.data, g);
            end
            checks++;
            if (err_bytes !== 32'h0 || err_bits !== 32'h0) begin
                errors++;
                $display("FAIL clean_no_errors: got eby=%h ebi=%h expected 0/0", err_bytes, err_bits);
            end
        end
    endtask

    task automatic test_single_error();
        logic [7:0] g;
        logic [7:0] mask;
        int         p0, p1, p2;
        p0 = $urandom_range(0, 7);
        p1 = (p0 + $urandom_range(1, 3)) % 8;
        p2 = (p1 + $urandom_range(1, 3)) % 8;
        if (p2 == p0) p2 = (p2 + 1) % 8;
        mask = 8'h00;
        mask[p0] = 1'b1; mask[p1] = 1'b1; mask[p2] = 1'b1;
        gen_next(g);
        send(1'b1, g ^ mask, 1'b0);
        checks++;
        if (err_bytes !== 32'd1 || err_bits !== 32'd3 || locked !== 1'b1) begin
            errors++;
            $display("FAIL single_error: got eby=%0d ebi=%0d lk=%b expected 1/3/1", err_bytes, err_bits, locked);
        end
        for (int k = 0; k < 3; k++) begin
            gen_next(g);
            send(1'b1, g, 1'b0);
            checks++;
            if (err_bytes !== 32'(m_eby) || err_bits !== 32'(m_ebi) || locked !== 1'b1) begin
                errors++;
                $display("FAIL single_error_recover: got eby=%0d ebi=%0d lk=%b expected %0d/%0d/1",
                         err_bytes, err_bits, locked, m_eby, m_ebi);
            end
        end
    endtask

    task automatic test_loss_relock();
        logic [7:0] g;
        logic [7:0] seed;
        longint     eby_hold, ebi_hold;
        for (int k = 1; k <= LOSS_CNT; k++) begin
            gen_next(g);
            send(1'b1, g ^ 8'($urandom_range(1, 255)), 1'b0);
            checks++;
            if (locked !== (k < LOSS_CNT) || err_bytes !== 32'(m_eby) || err_bits !== 32'(m_ebi)) begin
                errors++;
                $display("FAIL loss_seq miss %0d: got lk=%b eby=%0d ebi=%0d expected %b/%0d/%0d",
                         k, locked, err_bytes, err_bits, (k < LOSS_CNT), m_eby, m_ebi);
            end
        end
        checks++;
        if (err_bytes !== 32'd9) begin
            errors++;
            $display("FAIL loss_err_bytes: got %0d expected 9", err_bytes);
        end
        eby_hold = m_eby;
        ebi_hold = m_ebi;
        seed = {1'($urandom_range(0, 1)), 7'($urandom_range(1, 127))};
        gen_hist = hist_of(seed);
        send(1'b1, seed, 1'b0);
        for (int k = 1; k <= LOCK_CNT; k++) begin
            gen_next(g);
            send(1'b1, g, 1'b0);
            checks++;
            if (locked !== (k == LOCK_CNT) || err_bytes !== 32'(eby_hold) || err_bits !== 32'(ebi_hold)) begin
                errors++;
                $display("FAIL relock byte %0d: got lk=%b eby=%0d ebi=%0d expected %b/%0d/%0d",
                         k + 1, locked, err_bytes, err_bits, (k == LOCK_CNT), eby_hold, ebi_hold);
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] g;
        logic [7:0] seed;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (locked !== 1'b0 || err_bytes !== 32'h0 || err_bits !== 32'h0 || lp.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset: got lk=%b eby=%0d ebi=%0d dv=%b expected all 0",
                     locked, err_bytes, err_bits, lp.data_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 8'h80, 1'b0);
        checks++;
        if (dut.state !== 2'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL search_illegal_seed: got state=%0d lk=%b expected 0/0", dut.state, locked);
        end
        seed = {1'($urandom_range(0, 1)), 7'($urandom_range(1, 127))};
        gen_hist = hist_of(seed);
        send(1'b1, seed, 1'b0);
        for (int k = 1; k <= LOCK_CNT + 3; k++) begin
            for (int j = 0; j < 2; j++) begin
                send(1'b0, 8'($urandom), 1'b0);
                checks++;
                if (lp.data_valid !== 1'b0 || lp.data !== m_data) begin
                    errors++;
                    $display("FAIL gap_hold: got dv=%b d=%h expected dv=0 d=%h", lp.data_valid, lp.data, m_data);
                end
            end
            gen_next(g);
            send(1'b1, g, 1'b0);
            checks++;
            if (locked !== (k >= LOCK_CNT) || err_bytes !== 32'h0 || err_bits !== 32'h0) begin
                errors++;
                $display("FAIL gap_lock byte %0d: got lk=%b eby=%0d ebi=%0d expected %b/0/0",
                         k + 1, locked, err_bytes, err_bits, (k >= LOCK_CNT));
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] g;
        force dut.err_bits = 32'hFFFF_FFFE;
        #1;
        release dut.err_bits;
        m_ebi = 64'h0000_0000_FFFF_FFFE;
        gen_next(g);
        send(1'b1, g ^ 8'hFF, 1'b0);
        checks++;
        if (err_bits !== 32'hFFFF_FFFF || err_bytes !== 32'(m_eby)) begin
            errors++;
            $display("FAIL sat_bits: got ebi=%h eby=%0d expected FFFFFFFF/%0d", err_bits, err_bytes, m_eby);
        end
        gen_next(g);
        send(1'b1, g ^ 8'h01, 1'b0);
        checks++;
        if (err_bits !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_bits_hold: got %h expected FFFFFFFF", err_bits);
        end
        force dut.err_bytes = 32'hFFFF_FFFF;
        #1;
        release dut.err_bytes;
        m_eby = MAXC;
        gen_next(g);
        send(1'b1, g ^ 8'h10, 1'b0);
        checks++;
        if (err_bytes !== 32'hFFFF_FFFF || locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_bytes: got eby=%h lk=%b expected FFFFFFFF/1", err_bytes, locked);
        end
        gen_next(g);
        send(1'b1, g ^ 8'h3C, 1'b1);
        checks++;
        if (err_bytes !== 32'h0 || err_bits !== 32'h0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clear_wins: got eby=%h ebi=%h lk=%b expected 0/0/1", err_bytes, err_bits, locked);
        end
        gen_next(g);
        send(1'b1, g, 1'b0);
        checks++;
        if (err_bytes !== 32'h0 || err_bits !== 32'h0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL after_clear: got eby=%h ebi=%h lk=%b expected 0/0/1", err_bytes, err_bits, locked);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] g;
        logic [7:0] d;
        logic       v;
        logic       clr;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            if (v) begin
                gen_next(g);
                d = ($urandom_range(0, 5) == 0) ? (g ^ 8'($urandom_range(1, 255))) : g;
            end else begin
                d = 8'($urandom);
            end
            send(v, d, clr);
            checks++;
            if (locked !== (m_mode == 2) || err_bytes !== 32'(m_eby) || err_bits !== 32'(m_ebi)
                || lp.data_valid !== m_dv || lp.data !== m_data) begin
                errors++;
                $display("FAIL random_stream cyc %0d: got lk=%b eby=%0d ebi=%0d dv=%b d=%h expected %b/%0d/%0d/%b/%h",
                         n, locked, err_bytes, err_bits, lp.data_valid, lp.data,
                         (m_mode == 2), m_eby, m_ebi, m_dv, m_data);
            end
        end
    endtask

    initial begin
        lp.rx_valid = 1'b0;
        lp.rx_data  = 8'h00;
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_relock();
        test_gaps();
        test_saturation();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
